bit_cldiv: RTL and testbench

Iterative carry-less (GF(2) polynomial) divider for the bit-manipulation execute path: the inverse companion of the carry-less multiplier. It accepts a dividend/divisor pair on a one-cycle enable strobe and runs a bit-serial, MSB-first long division over XLEN cycles. It returns either the quotient (cldiv) or the remainder (clrem) with a one-cycle ready pulse. Its enable/op/rdata1/rdata2 → result/ready handshake matches the carry-less multiplier's, so the execute stage stalls on it the same way.

---
 rtl/bit_cldiv_if.sv | 23 ++
 rtl/bit_cldiv.sv | 103 ++++++++++
 tb/tb_bit_cldiv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bit_cldiv_if.sv
// Handshake bundle between the execute stage and the carry-less divider.
// It uses the same enable/op/rdata -> result/ready shape as the carry-less multiplier.
interface bit_cldiv_if #(
  parameter int XLEN = 32
);
  logic            enable;
  logic            op_cldiv;
  logic            op_clrem;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] result;
  logic            ready;

  modport master (
    output enable, op_cldiv, op_clrem, rdata1, rdata2,
    input  result, ready
  );

  modport slave (
    input  enable, op_cldiv, op_clrem, rdata1, rdata2,
    output result, ready
  );
endinterface

// File: rtl/bit_cldiv.sv
// Bit-serial, MSB-first carry-less (GF(2)) long divider.
// It returns the quotient or the remainder and pulses ready for one cycle.
module bit_cldiv #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  bit_cldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   deg_q;
  logic [CW-1:0]   deg_d;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] quot_d;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] shift_d;
  logic [XLEN-1:0] result_q;
  logic            opdiv_q;
  logic            ready_q;

  // The divisor degree is the highest set bit; the remainder never reaches it, so the shift is lossless.
  always_comb begin
    deg_d = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (bus.rdata2[i]) deg_d = i[CW-1:0];
    end
    shift_d = {rem_q[XLEN-2:0], dvd_q[cnt_q]};
    if (shift_d[deg_q]) begin
      rem_d  = shift_d ^ dvs_q;
      quot_d = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d  = shift_d;
      quot_d = {quot_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      deg_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      opdiv_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.enable && (bus.op_cldiv || bus.op_clrem)) begin
            dvd_q   <= bus.rdata1;
            dvs_q   <= bus.rdata2;
            opdiv_q <= bus.op_cldiv;
            deg_q   <= deg_d;
            cnt_q   <= CW'(XLEN - 1);
            if (bus.rdata2 != '0) begin
              quot_q  <= '0;
              rem_q   <= '0;
              state_q <= DIV;
            end else begin
              // A zero divisor skips the iteration: the quotient is all-ones and the remainder is the dividend.
              quot_q   <= '1;
              rem_q    <= bus.rdata1;
              result_q <= bus.op_cldiv ? '1 : bus.rdata1;
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DIV: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          if (cnt_q == '0) begin
            result_q <= opdiv_q ? quot_d : rem_d;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
endmodule

// File: tb/tb_bit_cldiv.sv
// Directed and random checks of the carry-less divider against a long-division model.
module tb_bit_cldiv;
  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  bit_cldiv_if #(.XLEN(32)) bus ();

  bit_cldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // The model divides by clearing dividend bits from the top down, not by iterating over a shifting remainder.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int degB;
    q = '0;
    r = a;
    degB = -1;
    for (int i = 0; i < 32; i++) if (b[i]) degB = i;
    if (degB < 0) return {32'hFFFFFFFF, a};
    for (int i = 31; i >= 0; i--) begin
      if (i >= degB && r[i]) begin
        r = r ^ (b << (i - degB));
        q[i - degB] = 1'b1;
      end
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] clMul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (a[i]) p = p ^ (b << i);
    return p;
  endfunction

  function automatic int degreeOf(input logic [31:0] v);
    int d;
    d = 0;
    for (int i = 0; i < 32; i++) if (v[i]) d = i;
    return d;
  endfunction

  // This task is entered at a negedge with the divider idle. It presents the start in the current cycle,
  // counts cycles until ready, and returns at the following negedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic opDiv,
                               input logic opRem, input logic pulseMid,
                               output logic [31:0] res, output int cyc);
    bus.enable   = 1'b1;
    bus.op_cldiv = opDiv;
    bus.op_clrem = opRem;
    bus.rdata1   = a;
    bus.rdata2   = b;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.rdata1 = $urandom;
    bus.rdata2 = $urandom;
    cyc = 1;
    while (!bus.ready && cyc < 100) begin
      bus.enable = pulseMid && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    bus.enable = 1'b0;
    checkOutput("readySeen", {31'b0, bus.ready}, 32'd1);
    res = bus.result;
    @(negedge clk);
    checkOutput("readyPulse", {31'b0, bus.ready}, 32'd0);
    checkOutput("resultHold", bus.result, res);
  endtask

  logic [31:0] res;
  logic [31:0] qDut;
  logic [31:0] rDut;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] model;
  int          cyc;
  int          readyHighs;

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    rst          = 1'b0;
    bus.enable   = 1'b0;
    bus.op_cldiv = 1'b0;
    bus.op_clrem = 1'b0;
    bus.rdata1   = '0;
    bus.rdata2   = '0;
    #2;
    checkOutput("resetResult", bus.result, 32'h0);
    checkOutput("resetReady", {31'b0, bus.ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(32'h00000080, 32'h0000000B, 1'b1, 1'b0, 1'b0, res, cyc);
    checkOutput("primDiv", res, 32'h00000017);
    checkOutput("primDivCycles", cyc, 32'd33);
    applyStimulus(32'h00000080, 32'h0000000B, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("primRem", res, 32'h00000001);
    applyStimulus(32'hDEADBEEF, 32'h00000001, 1'b1, 1'b0, 1'b0, res, cyc);
    checkOutput("unitDiv", res, 32'hDEADBEEF);
    applyStimulus(32'hDEADBEEF, 32'h00000001, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("unitRem", res, 32'h00000000);
    applyStimulus(32'h00000005, 32'h00000010, 1'b1, 1'b0, 1'b0, res, cyc);
    checkOutput("lowDegDiv", res, 32'h00000000);
    applyStimulus(32'h00000005, 32'h00000010, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("lowDegRem", res, 32'h00000005);
    applyStimulus(32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, res, cyc);
    checkOutput("topDegDiv", res, 32'h00000001);
    applyStimulus(32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("topDegRem", res, 32'h7FFFFFFF);
    applyStimulus(32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0, res, cyc);
    checkOutput("divZeroDiv", res, 32'hFFFFFFFF);
    checkOutput("divZeroCycles", cyc, 32'd1);
    applyStimulus(32'h00001234, 32'h00000000, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("divZeroRem", res, 32'h00001234);
    applyStimulus(32'h00000080, 32'h0000000B, 1'b1, 1'b0, 1'b1, res, cyc);
    checkOutput("midEnableDiv", res, 32'h00000017);
    checkOutput("midEnableCycles", cyc, 32'd33);
    applyStimulus(32'h00000080, 32'h0000000B, 1'b1, 1'b1, 1'b0, res, cyc);
    checkOutput("bothOpsDiv", res, 32'h00000017);

    // Reset is dropped between edges in cycle 10 of a division and must clear the outputs at once.
    bus.enable   = 1'b1;
    bus.op_cldiv = 1'b1;
    bus.op_clrem = 1'b0;
    bus.rdata1   = 32'hDEADBEEF;
    bus.rdata2   = 32'h00000001;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midResetResult", bus.result, 32'h0);
    checkOutput("midResetReady", {31'b0, bus.ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    readyHighs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) readyHighs++;
    end
    checkOutput("noReadyAfterReset", readyHighs, 32'd0);
    applyStimulus(32'h00000080, 32'h0000000B, 1'b0, 1'b1, 1'b0, res, cyc);
    checkOutput("postResetRem", res, 32'h00000001);
    checkOutput("postResetCycles", cyc, 32'd33);

    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (n % 60 == 0) b = '0;
      model = refDiv(a, b);
      applyStimulus(a, b, 1'b1, 1'b0, 1'b0, qDut, cyc);
      applyStimulus(a, b, 1'b0, 1'b1, 1'b0, rDut, cyc);
      checkOutput("randDiv", qDut, model[63:32]);
      checkOutput("randRem", rDut, model[31:0]);
      if (b != '0) begin
        checkOutput("randInvariant", clMul(qDut, b) ^ rDut, a);
        checkOutput("randRemDegree", rDut >> degreeOf(b), 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
